// File: rtl/itcm_ctrl_if.sv
// Fetch request / response channel interfaces for the instruction TCM.
// Both channels use a vld/rdy handshake; a transfer happens when both are high.

interface fch_req_if_t #(
  parameter int PC_W = 32
);
  typedef struct packed {
    logic [PC_W-1:0] pc;
  } pkt_t;

  logic vld;
  logic rdy;
  pkt_t pkt;

  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);
endinterface

interface fch_rsp_if_t #(
  parameter int IR_W = 32
);
  typedef struct packed {
    logic [IR_W-1:0] ir;
  } pkt_t;

  logic vld;
  logic rdy;
  pkt_t pkt;

  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/itcm_ctrl.sv
// Instruction TCM controller: single-port synchronous-read SRAM serving fetch
// requests, with a loader write port that takes strict priority and a
// 2-entry response FIFO that absorbs fetch-unit backpressure. Request
// acceptance is credit based so the FIFO can never overflow.

module itcm_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int RV_PC_SIZE = 32,
  parameter int RV_IR_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  fch_req_if_t.slv          fch_req_slv,
  fch_rsp_if_t.mst          fch_rsp_mst,
  input  logic              ld_vld,
  output logic              ld_rdy,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              fch_err
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int FIFO_N = 2;

  // Storage
  logic [31:0]           mem [DEPTH];
  logic [31:0]           rd_data_reg;
  logic [RV_IR_SIZE-1:0] fifo_data_reg [FIFO_N];

  // Control state
  logic       inflight_reg;      // a fetch was accepted last cycle
  logic       inflight_bad_reg;  // ...and it was a bad fetch (no SRAM read)
  logic [1:0] buf_cnt_reg;
  logic [1:0] buf_cnt_next;
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic       fch_err_reg;

  // Request decode
  logic [RV_PC_SIZE-1:0] req_pc;
  logic                  pc_misaligned;
  logic                  pc_out_of_range;
  logic                  pc_bad;
  logic [ADDR_W-1:0]     rd_addr;
  logic [2:0]            credits_used;
  logic                  req_rdy;
  logic                  req_fire;
  logic                  rd_en;

  // Response path
  logic [RV_IR_SIZE-1:0] ret_data;
  logic                  fifo_empty;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [RV_IR_SIZE-1:0] rsp_ir;
  logic                  push;
  logic                  pop_fifo;

  assign req_pc          = fch_req_slv.pkt.pc;
  assign pc_misaligned   = |req_pc[1:0];
  assign pc_out_of_range = |req_pc[RV_PC_SIZE-1:ADDR_W+2];
  assign pc_bad          = pc_misaligned | pc_out_of_range;
  assign rd_addr         = req_pc[ADDR_W+1:2];

  // Every accepted fetch holds one credit until its response leaves the
  // FIFO (or is taken straight off the bypass), so two credits cover the
  // two FIFO slots. The loader steals the SRAM port outright.
  assign credits_used = {2'b00, inflight_reg} + {1'b0, buf_cnt_reg};
  assign req_rdy      = ~rst & ~ld_vld & (credits_used < 3'd2);
  assign req_fire     = fch_req_slv.vld & req_rdy;
  assign rd_en        = req_fire & ~pc_bad;

  assign fch_req_slv.rdy = req_rdy;
  assign ld_rdy          = 1'b1;

  // SRAM port: loader write or fetch read (never both, loader blocks fetch)
  always_ff @(posedge clk) begin
    if (ld_vld) begin
      mem[ld_addr] <= ld_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  // Bad fetches keep their slot in the response stream but return zero
  assign ret_data = inflight_bad_reg ? '0 : RV_IR_SIZE'(rd_data_reg);

  assign fifo_empty = (buf_cnt_reg == 2'd0);
  assign rsp_rdy    = fch_rsp_mst.rdy;
  assign rsp_vld    = ~fifo_empty | inflight_reg;

  // FIFO head has precedence; otherwise the returning read bypasses the FIFO.
  always_comb begin
    rsp_ir = '0;
    if (!fifo_empty) begin
      rsp_ir = fifo_data_reg[rd_ptr_reg];
    end else if (inflight_reg) begin
      rsp_ir = ret_data;
    end
  end

  assign fch_rsp_mst.vld    = rsp_vld;
  assign fch_rsp_mst.pkt.ir = rsp_ir;

  // Returning data is buffered unless it was consumed on the bypass.
  assign pop_fifo = ~fifo_empty & rsp_rdy;
  assign push     = inflight_reg & ~(fifo_empty & rsp_rdy);

  // Occupancy update; simultaneous push and pop leaves the count unchanged
  always_comb begin
    buf_cnt_next = buf_cnt_reg;
    if (push && !pop_fifo) begin
      buf_cnt_next = buf_cnt_reg + 2'd1;
    end else if (!push && pop_fifo) begin
      buf_cnt_next = buf_cnt_reg - 2'd1;
    end
  end

  // Credit, pointer and error state; reset discards everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_reg     <= 1'b0;
      inflight_bad_reg <= 1'b0;
      buf_cnt_reg      <= 2'd0;
      wr_ptr_reg       <= 1'b0;
      rd_ptr_reg       <= 1'b0;
      fch_err_reg      <= 1'b0;
    end else begin
      inflight_reg     <= req_fire;
      inflight_bad_reg <= req_fire & pc_bad;
      buf_cnt_reg      <= buf_cnt_next;
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop_fifo) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      if (req_fire && pc_bad) begin
        fch_err_reg <= 1'b1;
      end
    end
  end

  assign fch_err = fch_err_reg;

  // One data register per FIFO slot, written when the write pointer selects it
  generate
    for (genvar gi = 0; gi < FIFO_N; gi++) begin : g_fifo
      // Capture returning data into this slot on a push
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == 1'(gi))) begin
          fifo_data_reg[gi] <= ret_data;
        end
      end
    end
  endgenerate

  // The credit scheme must make a push into a full FIFO impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (buf_cnt_reg == 2'd2)));

endmodule
